switch_port_ctrl: RTL and testbench
===================================

Name: switch_port_ctrl

Overview:
Parametrised per-input-port controller for the N-port packet switch, the successor to the fixed 4-port datapath. It buffers incoming single-word packets in a DEPTH-entry FIFO and classifies each packet as ERR, SDP, MDP or BDP. It requests all target output ports at once, waits for a simultaneous grant from the external per-output arbiters, and then launches the packet. Unlike the fixed design, it supports generic port count, multicast/broadcast all-or-nothing grants, an arbitration timeout with drop, and a saturating error counter.

Parameters:
NUM_PORTS, 4, number of switch ports; width of src/tgt one-hot fields.
PORT_ID, 0, index of this input port, 0..NUM_PORTS-1.
DATA_WIDTH, 16, packet word width; must be >= 2*NUM_PORTS+1.
DEPTH, 8, FIFO entries; power of two, >= 2.
ARB_TIMEOUT, 0, ARB_WAIT cycles before drop; 0 disables the timeout.
CNT_W, 8, width of err_cnt.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input word valid
in_data  in  DATA_WIDTH  packet: [NUM_PORTS-1:0]=src one-hot, [2*NUM_PORTS-1:NUM_PORTS]=tgt mask, upper bits=payload
in_ready  out  1  equals !fifo_full; a word is accepted when in_valid && in_ready
req  out  NUM_PORTS  output-port request mask to arbiters
gnt  in  NUM_PORTS  grants from arbiters
out_valid  out  NUM_PORTS  destination mask, asserted for one cycle
out_data  out  DATA_WIDTH  packet word, valid when out_valid != 0
pkt_type  out  2  p_type of the current packet, updated in ROUTE
cur_state  out  2  FSM state (state enum)
drop  out  1  one-cycle pulse when a packet times out
err_cnt  out  CNT_W  saturating count of ERR packets

Behaviour:
- Reset: FSM=IDLE, FIFO empty, pkt_reg=0; req, out_valid, out_data, pkt_type(ERR), drop and err_cnt are all 0; in_ready=1.
- FIFO: push on in_valid && in_ready. When full, in_ready=0 even if a pop occurs in the same cycle (no bypass). Pointers wrap modulo DEPTH; full/empty are derived from a count of width clog2(DEPTH)+1.
- IDLE: if FIFO not empty, pop the head into pkt_reg and go to ROUTE. Otherwise stay.
- ROUTE (1 cycle), classification:
  - ERR if tgt==0, or tgt[PORT_ID]==1, or src != (1<<PORT_ID).
  - BDP if tgt == all-ones with bit PORT_ID cleared.
  - SDP if popcount(tgt)==1.
  - MDP otherwise.
  - For BDP with NUM_PORTS==2, BDP takes priority over SDP.
- ROUTE outcomes:
  - ERR: err_cnt += 1, saturating at all-ones; no request; go to IDLE.
  - Otherwise: req <= tgt, wait_cnt <= 0, go to ARB_WAIT.
- ARB_WAIT:
  - req held stable.
  - If (gnt & req) == req: out_valid <= req, out_data <= pkt_reg, req <= 0, go to TRANSMIT.
  - Partial grants are ignored; the grant must cover all requested bits in the same cycle. Extra gnt bits outside req are ignored.
  - Timeout: if ARB_TIMEOUT != 0 and wait_cnt == ARB_TIMEOUT-1 without a full grant: req <= 0, drop pulses, go to IDLE.
  - A full grant in the timeout cycle wins over the drop.
  - Otherwise wait_cnt increments.
- TRANSMIT (1 cycle): out_valid/out_data are visible this cycle; they clear on the next edge, and the FSM goes to IDLE.
- Latency: word accepted at edge 0 with immediate full grant gives out_valid during cycle 4. Minimum 4 cycles per packet; throughput is 1 packet per 4 cycles.
- Reset mid-operation clears everything asynchronously; an in-flight packet and the FIFO contents are lost.

Decomposition:
- packet_pkg: keep the state and p_type enums.
- packet_pkg additions:
  - Localparams derived from DATA_WIDTH/ADDR_WIDTH/DEPTH.
  - Functions get_src/get_tgt (field extraction).
  - classify(src, tgt, port_id) returning p_type.
  - popcount.
- Sub-module pkt_fifo (DATA_WIDTH, DEPTH): synchronous FIFO with push/pop/full/empty/dout. dout shows the head word combinationally.

Test Plan:
- SDP (PORT_ID=0, 4 ports): in_data=16'hA521, gnt tied to req -> pkt_type=SDP, out_valid=4'b0010, out_data=16'hA521 four cycles after acceptance.
- BDP partial grant: in_data=16'h3CE1, gnt=4'b0110 for 5 cycles then 4'b1110 -> no out_valid while partial; then out_valid=4'b1110 for exactly one cycle.
- ERR: in_data=16'h0011 (tgt includes own port) -> pkt_type=ERR, err_cnt 0->1, req stays 0, FSM returns to IDLE. 300 ERR words with CNT_W=8 -> err_cnt=8'hFF.
- Full/back-pressure: gnt=0, ARB_TIMEOUT=0, in_valid high for 12 cycles -> exactly 9 words accepted (1 in pkt_reg, 8 in FIFO), then in_ready=0. After granting, all 9 exit in order.
- Timeout: ARB_TIMEOUT=16, gnt=0 -> drop pulses after 16 ARB_WAIT cycles, req->0, next packet is popped. A full grant in cycle 16 transmits instead of dropping.
- Reset during TRANSMIT -> out_valid, req, err_cnt = 0 asynchronously, in_ready=1, cur_state=IDLE.

Source files
------------

// File: rtl/packet_pkg.sv
// Shared types and helpers for the switch input-port controller:
// FSM state and packet-type enums, header field extraction and classification.
package packet_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ROUTE    = 2'd1,
        ARB_WAIT = 2'd2,
        TRANSMIT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR = 2'd0,
        SDP = 2'd1,
        MDP = 2'd2,
        BDP = 2'd3
    } p_type_t;

    // Helpers operate on fixed maximum-width containers so that any port
    // count / word width up to these limits can share one implementation.
    localparam int MAX_PORTS  = 32;
    localparam int MAX_DATA_W = 2 * MAX_PORTS + 64;

    typedef logic [MAX_PORTS-1:0]  port_mask_t;
    typedef logic [MAX_DATA_W-1:0] word_t;

    // Occupancy counter width for a FIFO of the given depth (one extra bit
    // so that full and empty are distinguishable).
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Mask with the low n bits set.
    function automatic port_mask_t low_mask(input int n);
        if (n >= MAX_PORTS) begin
            return '1;
        end
        return (port_mask_t'(1) << n) - port_mask_t'(1);
    endfunction

    // Source one-hot field: bits [num_ports-1:0].
    function automatic port_mask_t get_src(input word_t word, input int num_ports);
        return port_mask_t'(word) & low_mask(num_ports);
    endfunction

    // Target mask field: bits [2*num_ports-1:num_ports].
    function automatic port_mask_t get_tgt(input word_t word, input int num_ports);
        return port_mask_t'(word >> num_ports) & low_mask(num_ports);
    endfunction

    function automatic int unsigned popcount(input port_mask_t m);
        int unsigned c;
        c = 0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (m[i]) begin
                c++;
            end
        end
        return c;
    endfunction

    // Broadcast is tested before single-destination so that a 2-port
    // switch (where broadcast is a single bit) reports BDP.
    function automatic p_type_t classify(input port_mask_t src, input port_mask_t tgt,
                                         input int port_id, input int num_ports);
        port_mask_t own;
        port_mask_t bcast;
        own   = port_mask_t'(1) << port_id;
        bcast = low_mask(num_ports) & ~own;
        if (tgt == '0 || (tgt & own) != '0 || src != own) begin
            return ERR;
        end
        if (tgt == bcast) begin
            return BDP;
        end
        if (popcount(tgt) == 1) begin
            return SDP;
        end
        return MDP;
    endfunction

endpackage

// File: rtl/pkt_fifo.sv
// Synchronous single-clock FIFO; the head word is presented combinationally
// on dout. Push while full and pop while empty are ignored.
module pkt_fifo
    import packet_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);

    localparam int ADDR_W    = $clog2(DEPTH);
    localparam int CNT_WIDTH = cnt_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [CNT_WIDTH-1:0]  count;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (count == CNT_WIDTH'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/switch_port_ctrl.sv
// Per-input-port controller: buffers single-word packets, classifies them,
// requests every target output at once and launches only on a grant that
// covers the whole request in one cycle. Optional arbitration timeout drops
// the packet; ERR packets are counted with saturation.
module switch_port_ctrl
    import packet_pkg::*;
#(
    parameter int NUM_PORTS   = 4,
    parameter int PORT_ID     = 0,
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH       = 8,
    parameter int ARB_TIMEOUT = 0,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic [NUM_PORTS-1:0]  req,
    input  logic [NUM_PORTS-1:0]  gnt,
    output logic [NUM_PORTS-1:0]  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            pkt_type,
    output logic [1:0]            cur_state,
    output logic                  drop,
    output logic [CNT_W-1:0]      err_cnt
);

    localparam int WAIT_W = (ARB_TIMEOUT > 1) ? $clog2(ARB_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((ARB_TIMEOUT > 0) ? ARB_TIMEOUT - 1 : 0);

    state_t                state;
    state_t                state_n;
    logic [DATA_WIDTH-1:0] pkt_reg;
    logic [DATA_WIDTH-1:0] pkt_reg_n;
    logic [NUM_PORTS-1:0]  req_n;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [WAIT_W-1:0]     wait_cnt_n;
    logic [NUM_PORTS-1:0]  out_valid_n;
    logic [DATA_WIDTH-1:0] out_data_n;
    p_type_t               pkt_type_q;
    p_type_t               pkt_type_n;
    logic                  drop_n;
    logic [CNT_W-1:0]      err_cnt_n;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_dout;

    logic [NUM_PORTS-1:0]  tgt;
    p_type_t               route_type;

    // No bypass: a full FIFO refuses input even when it pops that cycle.
    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;

    pkt_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (in_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tgt        = pkt_reg[2*NUM_PORTS-1:NUM_PORTS];
    assign route_type = classify(get_src(word_t'(pkt_reg), NUM_PORTS),
                                 get_tgt(word_t'(pkt_reg), NUM_PORTS),
                                 PORT_ID, NUM_PORTS);

    assign cur_state = state;
    assign pkt_type  = pkt_type_q;

    // Next-state and registered-output logic for IDLE/ROUTE/ARB_WAIT/TRANSMIT.
    always_comb begin
        state_n     = state;
        pkt_reg_n   = pkt_reg;
        req_n       = req;
        wait_cnt_n  = wait_cnt;
        out_valid_n = '0;
        out_data_n  = '0;
        pkt_type_n  = pkt_type_q;
        drop_n      = 1'b0;
        err_cnt_n   = err_cnt;
        fifo_pop    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    pkt_reg_n = fifo_dout;
                    state_n   = ROUTE;
                end
            end
            ROUTE: begin
                pkt_type_n = route_type;
                if (route_type == ERR) begin
                    if (err_cnt != '1) begin
                        err_cnt_n = err_cnt + CNT_W'(1);
                    end
                    state_n = IDLE;
                end else begin
                    req_n      = tgt;
                    wait_cnt_n = '0;
                    state_n    = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                // A complete grant beats a timeout landing in the same cycle.
                if ((gnt & req) == req) begin
                    out_valid_n = req;
                    out_data_n  = pkt_reg;
                    req_n       = '0;
                    state_n     = TRANSMIT;
                end else if (ARB_TIMEOUT != 0 && wait_cnt == WAIT_LAST) begin
                    req_n   = '0;
                    drop_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    wait_cnt_n = wait_cnt + WAIT_W'(1);
                end
            end
            TRANSMIT: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers, all cleared asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pkt_reg    <= '0;
            req        <= '0;
            wait_cnt   <= '0;
            out_valid  <= '0;
            out_data   <= '0;
            pkt_type_q <= ERR;
            drop       <= 1'b0;
            err_cnt    <= '0;
        end else begin
            state      <= state_n;
            pkt_reg    <= pkt_reg_n;
            req        <= req_n;
            wait_cnt   <= wait_cnt_n;
            out_valid  <= out_valid_n;
            out_data   <= out_data_n;
            pkt_type_q <= pkt_type_n;
            drop       <= drop_n;
            err_cnt    <= err_cnt_n;
        end
    end

endmodule

// File: tb/tb_switch_port_ctrl.sv
// Scoreboard bench for switch_port_ctrl (4 ports, PORT_ID 0, timeout 16).
module tb_switch_port_ctrl;
    import packet_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [3:0]  out_valid;
    logic [15:0] out_data;
    logic [1:0]  pkt_type;
    logic [1:0]  cur_state;
    logic        drop;
    logic [7:0]  err_cnt;

    logic        gnt_tie;
    logic [3:0]  gnt_man;
    assign gnt = gnt_tie ? req : gnt_man;

    typedef struct packed {
        logic [3:0]  mask;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    switch_port_ctrl #(
        .NUM_PORTS   (4),
        .PORT_ID     (0),
        .DATA_WIDTH  (16),
        .DEPTH       (8),
        .ARB_TIMEOUT (16),
        .CNT_W       (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .req       (req),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .pkt_type  (pkt_type),
        .cur_state (cur_state),
        .drop      (drop),
        .err_cnt   (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] w);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        chk("push_ready", 64'(in_ready), 64'h1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_state(input state_t s, input int bound, input string tag);
        int n;
        n = 0;
        while (cur_state != s && n < bound) begin
            tick();
            n++;
        end
        chk(tag, 64'(cur_state), 64'(s));
    endtask

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || cur_state != IDLE) && n < bound) begin
            tick();
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'h0);
        repeat (3) tick();
    endtask

    function automatic logic [15:0] mkw(input int i);
        logic [3:0] t;
        case (i % 3)
            0:       t = 4'b0010;
            1:       t = 4'b0100;
            default: t = 4'b1000;
        endcase
        return {8'(16 + i), t, 4'b0001};
    endfunction

    // Output monitor: every launched packet must match the queue head.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (out_valid != 4'b0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 64'(out_valid), 64'h0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_mask", 64'(out_valid), 64'(mon_e.mask));
                    chk("sb_data", 64'(out_data), 64'(mon_e.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        int idx;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        gnt_tie  = 1'b1;
        gnt_man  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  64'(in_ready),  64'h1);
        chk("rst_state",     64'(cur_state), 64'(IDLE));
        chk("rst_req",       64'(req),       64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_data",  64'(out_data),  64'h0);
        chk("rst_pkt_type",  64'(pkt_type),  64'(ERR));
        chk("rst_drop",      64'(drop),      64'h0);
        chk("rst_err_cnt",   64'(err_cnt),   64'h0);
        rst = 1'b0;
        tick();

        // SDP with grant tied to request: launch three edges after acceptance
        exp_q.push_back('{mask: 4'b0010, data: 16'hA521});
        push_word(16'hA521);
        tick();
        chk("sdp_lat1", 64'(out_valid), 64'h0);
        tick();
        chk("sdp_lat2", 64'(out_valid), 64'h0);
        tick();
        chk("sdp_valid", 64'(out_valid), 64'h2);
        chk("sdp_data",  64'(out_data),  64'hA521);
        chk("sdp_type",  64'(pkt_type),  64'(SDP));
        tick();
        chk("sdp_clear", 64'(out_valid), 64'h0);
        wait_drain(50);

        // BDP with partial grant for five cycles, then full grant
        gnt_tie = 1'b0;
        gnt_man = 4'b0110;
        exp_q.push_back('{mask: 4'b1110, data: 16'h3CE1});
        push_word(16'h3CE1);
        idx = 0;
        while (req == 4'b0 && idx < 20) begin
            tick();
            idx++;
        end
        chk("bdp_req",  64'(req),      64'hE);
        chk("bdp_type", 64'(pkt_type), 64'(BDP));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bdp_partial", 64'(out_valid), 64'h0);
        end
        gnt_man = 4'b1110;
        tick();
        chk("bdp_valid", 64'(out_valid), 64'hE);
        chk("bdp_data",  64'(out_data),  64'h3CE1);
        tick();
        chk("bdp_one_cycle", 64'(out_valid), 64'h0);
        gnt_man = 4'b0;
        gnt_tie = 1'b1;
        wait_drain(50);

        // MDP with extra grant bits outside the request
        gnt_tie = 1'b0;
        gnt_man = 4'b1111;
        exp_q.push_back('{mask: 4'b0110, data: 16'h5A61});
        push_word(16'h5A61);
        wait_state(TRANSMIT, 20, "mdp_transmit");
        chk("mdp_type", 64'(pkt_type), 64'(MDP));
        gnt_man = 4'b0;
        gnt_tie = 1'b1;
        wait_drain(50);

        // ERR: target includes own port
        push_word(16'h0011);
        repeat (3) tick();
        chk("err_cnt1",  64'(err_cnt),   64'h1);
        chk("err_type",  64'(pkt_type),  64'(ERR));
        chk("err_req",   64'(req),       64'h0);
        chk("err_state", 64'(cur_state), 64'(IDLE));

        // 299 more ERR words: counter saturates at 8'hFF
        for (int i = 0; i < 299; i++) begin
            case (i % 3)
                0:       push_word(16'h0000);
                1:       push_word(16'h0022);
                default: push_word(16'h0011);
            endcase
        end
        repeat (10) tick();
        wait_state(IDLE, 20, "err_idle");
        chk("err_sat", 64'(err_cnt), 64'hFF);

        // Back-pressure: no grants, offer words for 12 cycles
        gnt_tie  = 1'b0;
        gnt_man  = 4'b0;
        accepted = 0;
        idx      = 0;
        for (int c = 0; c < 12; c++) begin
            in_valid = 1'b1;
            in_data  = mkw(idx);
            if (in_ready) begin
                exp_q.push_back('{mask: mkw(idx)[7:4], data: mkw(idx)});
                accepted++;
                idx++;
            end
            tick();
        end
        in_valid = 1'b0;
        chk("bp_accepted", 64'(accepted), 64'd9);
        chk("bp_in_ready", 64'(in_ready), 64'h0);
        gnt_tie = 1'b1;
        wait_drain(200);

        // Timeout: first packet dropped after 16 ARB_WAIT cycles
        gnt_tie = 1'b0;
        gnt_man = 4'b0;
        exp_q.push_back('{mask: 4'b1000, data: 16'hC281});
        push_word(16'hC141);
        push_word(16'hC281);
        wait_state(ARB_WAIT, 20, "to_enter");
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk("to_no_drop", 64'(drop), 64'h0);
        end
        chk("to_req_held", 64'(req), 64'h4);
        tick();
        chk("to_drop",      64'(drop),      64'h1);
        chk("to_req_clear", 64'(req),       64'h0);
        chk("to_idle",      64'(cur_state), 64'(IDLE));
        tick();
        chk("to_next_pop",  64'(cur_state), 64'(ROUTE));
        chk("to_drop_once", 64'(drop),      64'h0);
        gnt_tie = 1'b1;
        wait_drain(50);

        // Full grant in the timeout cycle transmits instead of dropping
        gnt_tie = 1'b0;
        gnt_man = 4'b0;
        exp_q.push_back('{mask: 4'b0010, data: 16'hC321});
        push_word(16'hC321);
        wait_state(ARB_WAIT, 20, "tg_enter");
        repeat (15) tick();
        chk("tg_still_wait", 64'(cur_state), 64'(ARB_WAIT));
        gnt_man = 4'b0010;
        tick();
        chk("tg_valid",   64'(out_valid), 64'h2);
        chk("tg_no_drop", 64'(drop),      64'h0);
        tick();
        chk("tg_no_late_drop", 64'(drop), 64'h0);
        gnt_man = 4'b0;
        gnt_tie = 1'b1;
        wait_drain(50);

        // Asynchronous reset during TRANSMIT; queued word must be lost
        exp_q.push_back('{mask: 4'b0100, data: 16'hC441});
        push_word(16'hC441);
        push_word(16'hC581);
        wait_state(TRANSMIT, 20, "rs_transmit");
        #2;
        rst = 1'b1;
        #1;
        chk("rs_out_valid", 64'(out_valid), 64'h0);
        chk("rs_req",       64'(req),       64'h0);
        chk("rs_err_cnt",   64'(err_cnt),   64'h0);
        chk("rs_in_ready",  64'(in_ready),  64'h1);
        chk("rs_state",     64'(cur_state), 64'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        repeat (20) tick();
        chk("rs_flushed",   64'(cur_state),    64'(IDLE));
        chk("rs_queue",     64'(exp_q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
